double_pair_gen: RTL and testbench

// Hardware stimulus source for the double-precision comparator blocks (double_eq and peers).

---
 rtl/double_pair_gen.sv | 121 ++++++++++++
 tb/tb_double_pair_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/double_pair_gen.sv
// LFSR-driven 64-bit operand-pair source with a valid/ready handshake and periodic b == a forcing.
// Optional macro DOUBLE_PAIR_GEN_SPECIALS_EN prepends up to eight fixed IEEE-754 special-value pairs.
module double_pair_gen #(
  parameter logic [63:0] SEED_A   = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED_B   = 64'hFEDC_BA98_7654_3210,
  parameter int unsigned N_PAIRS  = 1000,
  parameter int unsigned EQ_EVERY = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             ready_i,
  output logic [63:0]      a_o,
  output logic [63:0]      b_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pair_count_o
);

  localparam logic [63:0] SeedA  = (SEED_A == 64'h0) ? 64'h1 : SEED_A;
  localparam logic [63:0] SeedB  = (SEED_B == 64'h0) ? 64'h1 : SEED_B;
  localparam logic [63:0] Taps   = 64'hD800_0000_0000_0000;
  localparam int unsigned PhW    = (EQ_EVERY > 1) ? $clog2(EQ_EVERY) : 1;
  localparam int unsigned EqLast = (EQ_EVERY > 0) ? EQ_EVERY - 1 : 0;

  typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

  state_e           state_q, state_d;
  logic [63:0]      lfsr_a_q, lfsr_a_d;
  logic [63:0]      lfsr_b_q, lfsr_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PhW-1:0]   phase_q, phase_d;

  logic        in_spec;
  logic [63:0] spec_a, spec_b;
  logic        force_eq;

`ifdef DOUBLE_PAIR_GEN_SPECIALS_EN
  assign in_spec = (32'(cnt_q) < 32'd8);

  always_comb begin
    spec_a = 64'h0;
    spec_b = 64'h0;
    unique case (cnt_q[2:0])
      3'd0: begin spec_a = 64'h0000_0000_0000_0000; spec_b = 64'h8000_0000_0000_0000; end
      3'd1: begin spec_a = 64'h7FF0_0000_0000_0000; spec_b = 64'h7FF0_0000_0000_0000; end
      3'd2: begin spec_a = 64'h7FF8_0000_0000_0000; spec_b = 64'h7FF8_0000_0000_0000; end
      3'd3: begin spec_a = 64'h7FF0_0000_0000_0000; spec_b = 64'hFFF0_0000_0000_0000; end
      3'd4: begin spec_a = 64'h3FF0_0000_0000_0000; spec_b = 64'h3FF0_0000_0000_0000; end
      3'd5: begin spec_a = 64'h8000_0000_0000_0000; spec_b = 64'h0000_0000_0000_0000; end
      3'd6: begin spec_a = 64'h7FF8_0000_0000_0000; spec_b = 64'h3FF0_0000_0000_0000; end
      3'd7: begin spec_a = 64'h0000_0000_0000_0001; spec_b = 64'h0000_0000_0000_0001; end
      default: ;
    endcase
  end
`else
  assign in_spec = 1'b0;
  assign spec_a  = 64'h0;
  assign spec_b  = 64'h0;
`endif

  // Phase counter tracks k mod EQ_EVERY over LFSR-derived pairs only.
  assign force_eq = !in_spec && (EQ_EVERY != 0) && (phase_q == PhW'(EqLast));

  assign valid_o      = (state_q == StGen);
  assign busy_o       = (state_q == StGen);
  assign done_o       = (state_q == StDone);
  assign pair_count_o = cnt_q;
  assign a_o = !valid_o ? 64'h0 : (in_spec ? spec_a : lfsr_a_q);
  assign b_o = !valid_o ? 64'h0 : (in_spec ? spec_b : (force_eq ? lfsr_a_q : lfsr_b_q));

  always_comb begin
    state_d  = state_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d  = StGen;
          lfsr_a_d = SeedA;
          lfsr_b_d = SeedB;
          cnt_d    = '0;
          phase_d  = '0;
        end
      end
      StGen: begin
        if (ready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!in_spec) begin
            lfsr_a_d = (lfsr_a_q >> 1) ^ (lfsr_a_q[0] ? Taps : 64'h0);
            lfsr_b_d = (lfsr_b_q >> 1) ^ (lfsr_b_q[0] ? Taps : 64'h0);
            phase_d  = (phase_q == PhW'(EqLast)) ? '0 : phase_q + PhW'(1);
          end
          if (cnt_q == CNT_W'(N_PAIRS - 1)) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lfsr_a_q <= 64'h0;
      lfsr_b_q <= 64'h0;
      cnt_q    <= '0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: tb/tb_double_pair_gen.sv
// Bench for double_pair_gen: hand-derived vector table, start/reset corner cases and a
// randomized-ready full run checked against a pair-index reference model.
module tb_double_pair_gen;

  localparam logic [63:0] SA    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SB    = 64'hFEDC_BA98_7654_3210;
  localparam int          N     = 1000;
  localparam int          EQ    = 4;
`ifdef DOUBLE_PAIR_GEN_SPECIALS_EN
  localparam bit          Spec  = 1'b1;
`else
  localparam bit          Spec  = 1'b0;
`endif
  localparam int          NSpec = Spec ? ((N < 8) ? N : 8) : 0;

  localparam logic [63:0] SP_A [8] = '{64'h0, 64'h7FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000,
    64'h7FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000,
    64'h7FF8_0000_0000_0000, 64'h1};
  localparam logic [63:0] SP_B [8] = '{64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
    64'h7FF8_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h0,
    64'h3FF0_0000_0000_0000, 64'h1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [63:0] a, b;
  logic        valid, busy, done;
  logic [15:0] pair_count;

  double_pair_gen #(
    .SEED_A(SA), .SEED_B(SB), .N_PAIRS(N), .EQ_EVERY(EQ), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .ready_i(ready),
    .a_o(a), .b_o(b), .valid_o(valid), .busy_o(busy), .done_o(done),
    .pair_count_o(pair_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: state of both sequences plus the index of the pair on offer.
  logic [63:0] ma, mb;
  int          mk;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [63:0] exp_a(input int k);
    if (k < NSpec) return SP_A[k];
    return ma;
  endfunction

  function automatic logic [63:0] exp_b(input int k);
    int j;
    if (k < NSpec) return SP_B[k];
    j = k - NSpec;
    if (EQ != 0 && (j % EQ) == EQ - 1) return ma;
    return mb;
  endfunction

  task automatic model_start();
    ma = SA;
    mb = SB;
    mk = 0;
  endtask

  task automatic model_xfer();
    if (mk >= NSpec) begin
      ma = lfsr_next(ma);
      mb = lfsr_next(mb);
    end
    mk++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [63:0] ea;
    logic [63:0] eb;
  } vec_t;
  vec_t vt[4];

  initial begin
    int cyc;
    int stall_left;
    bit stalled;
    int budget;

`ifdef DOUBLE_PAIR_GEN_SPECIALS_EN
    vt[0] = '{0, 64'h0, 64'h8000_0000_0000_0000};
    vt[1] = '{2, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000};
    vt[2] = '{5, 64'h8000_0000_0000_0000, 64'h0};
    vt[3] = '{8, SA, SB};
`else
    vt[0] = '{0, SA, SB};
    vt[1] = '{1, 64'hD891_A2B3_C4D5_E6F7, 64'h7F6E_5D4C_3B2A_1908};
    vt[2] = '{2, 64'hB448_D159_E26A_F37B, 64'h3FB7_2EA6_1D95_0C84};
    vt[3] = '{3, 64'h8224_68AC_F135_79BD, 64'h8224_68AC_F135_79BD};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(pair_count), 64'd0);
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", 64'(valid), 64'd0);

    // Directed vectors with continuous ready
    ready = 1'b1;
    pulse_start();
    chk("latency_valid", 64'(valid), 64'd1);
    chk("latency_busy", 64'(busy), 64'd1);
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      while (cyc < vt[i].k) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("vec%0d_a", i), a, vt[i].ea);
      chk($sformatf("vec%0d_b", i), b, vt[i].eb);
      chk($sformatf("vec%0d_count", i), 64'(pair_count), 64'(vt[i].k));
    end

    // start during GEN is ignored (ready low so nothing moves)
    ready = 1'b0;
    pulse_start();
    chk("gen_start_count", 64'(pair_count), 64'(vt[3].k));
    chk("gen_start_a", a, vt[3].ea);
    chk("gen_start_busy", 64'(busy), 64'd1);

    // Asynchronous reset mid-run
    ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_count", 64'(pair_count), 64'd0);
    chk("arst_a", a, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_valid", 64'(valid), 64'd0);

    // Full run with random back-pressure and one 5-cycle stall
    model_start();
    pulse_start();
    stalled    = 1'b0;
    stall_left = 0;
    budget     = 20000;
    while (mk < N && budget > 0) begin
      budget--;
      chk("run_valid", 64'(valid), 64'd1);
      chk("run_a", a, exp_a(mk));
      chk("run_b", b, exp_b(mk));
      chk("run_count", 64'(pair_count), 64'(mk));
      if (mk == 500 && !stalled) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = ($urandom_range(3) != 0);
      end
      @(posedge clk);
      if (ready) model_xfer();
      @(negedge clk);
    end
    if (budget == 0) chk("run_timeout", 64'(mk), 64'(N));
    chk("end_transfers", 64'(mk), 64'(N));
    chk("end_done", 64'(done), 64'd1);
    chk("end_valid", 64'(valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_count", 64'(pair_count), 64'(N));
    chk("end_a", a, 64'd0);
    repeat (3) @(negedge clk);
    chk("end_hold_count", 64'(pair_count), 64'(N));
    chk("end_hold_done", 64'(done), 64'd1);

    // Restart from DONE
    model_start();
    ready = 1'b0;
    pulse_start();
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_valid", 64'(valid), 64'd1);
    chk("restart_count", 64'(pair_count), 64'd0);
    chk("restart_a", a, exp_a(0));
    chk("restart_b", b, exp_b(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
